// File: rtl/seg_disp_arbiter.sv
// seg_disp_arbiter: round-robin owner of the seven-segment display with a minimum hold tenure.
// Define SEG_ARB_PREEMPT_EN to let r1 (debug) preempt r0 (CPU) regardless of the hold counter.
module seg_disp_arbiter #(
   parameter int HOLD_CYCLES = 12500000,
   parameter int CNT_W = 24,
   parameter logic [31:0] IDLE_VAL = 32'h23333333
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        r0_req,
   input  logic        r0_we,
   input  logic [31:0] r0_din,
   output logic        r0_gnt,
   input  logic        r1_req,
   input  logic        r1_we,
   input  logic [31:0] r1_din,
   output logic        r1_gnt,
   output logic        seg_we,
   output logic [31:0] seg_din
);
   localparam logic [1:0] IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2;
   logic [1:0] state, nxt;
   logic [CNT_W-1:0] cnt;
   logic ptr;
   logic [31:0] sh0, sh1, nsh0, nsh1;
   logic expired, pre;
   assign nsh0 = r0_we ? r0_din : sh0;
   assign nsh1 = r1_we ? r1_din : sh1;
   assign expired = cnt == '0;
`ifdef SEG_ARB_PREEMPT_EN
   assign pre = 1'b1;
`else
   assign pre = 1'b0;
`endif
   // ptr=1 means the next contended IDLE grant goes to r1
   always_comb begin
      nxt = IDLE;
      nxt = state == IDLE ? (r0_req && r1_req ? (ptr ? OWN1 : OWN0) : r0_req ? OWN0 : r1_req ? OWN1 : IDLE) :
            state == OWN0 ? (!r0_req ? (r1_req ? OWN1 : IDLE) : (r1_req && (expired || pre)) ? OWN1 : OWN0) :
            state == OWN1 ? (!r1_req ? (r0_req ? OWN0 : IDLE) : (r0_req && expired) ? OWN0 : OWN1) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         r0_gnt <= 1'b0;
         r1_gnt <= 1'b0;
         seg_we <= 1'b0;
         seg_din <= '0;
         sh0 <= '0;
         sh1 <= '0;
         cnt <= '0;
         ptr <= 1'b0;
      end else begin
         state <= nxt;
         r0_gnt <= nxt == OWN0;
         r1_gnt <= nxt == OWN1;
         if (r0_we) sh0 <= r0_din;
         if (r1_we) sh1 <= r1_din;
         seg_we <= 1'b0;
         cnt <= expired ? '0 : cnt - 1'b1;
         // an ownership change always refreshes the display, overriding any owner write
         if (nxt != state) begin
            seg_we <= 1'b1;
            if (nxt == OWN0) begin
               seg_din <= nsh0;
               cnt <= CNT_W'(HOLD_CYCLES - 1);
               ptr <= 1'b1;
            end else if (nxt == OWN1) begin
               seg_din <= nsh1;
               cnt <= CNT_W'(HOLD_CYCLES - 1);
               ptr <= 1'b0;
            end else begin
               seg_din <= IDLE_VAL;
            end
         end else if (state == OWN0 && r0_we) begin
            seg_we <= 1'b1;
            seg_din <= r0_din;
         end else if (state == OWN1 && r1_we) begin
            seg_we <= 1'b1;
            seg_din <= r1_din;
         end
      end
   end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb_seg_disp_arbiter: scoreboard bench for seg_disp_arbiter with an owner/tenure reference model.
module tb_seg_disp_arbiter;
   localparam int HOLD = 8;
   localparam logic [31:0] IDLE_VAL = 32'h23333333;
`ifdef SEG_ARB_PREEMPT_EN
   localparam logic PRE = 1'b1;
`else
   localparam logic PRE = 1'b0;
`endif
   logic clk = 0, rst = 1;
   logic r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
   logic [31:0] r0_din = 0, r1_din = 0;
   logic r0_gnt, r1_gnt, seg_we;
   logic [31:0] seg_din;
   int checks = 0, errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_last = 0;
   logic [1:0] exp_gnt = 0;
   logic armed = 0;
   int m_owner = -1, m_held = 0, m_fav = 0;
   logic [31:0] m_sh[2];

   seg_disp_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(24), .IDLE_VAL(IDLE_VAL)) dut (
      .clk(clk), .rst(rst),
      .r0_req(r0_req), .r0_we(r0_we), .r0_din(r0_din), .r0_gnt(r0_gnt),
      .r1_req(r1_req), .r1_we(r1_we), .r1_din(r1_din), .r1_gnt(r1_gnt),
      .seg_we(seg_we), .seg_din(seg_din)
   );

   always #5 clk = ~clk;

   // drive one cycle of inputs and advance the reference model for the coming edge
   task automatic step(input logic rs, input logic q0, input logic w0, input logic [31:0] d0,
                       input logic q1, input logic w1, input logic [31:0] d1);
      logic req[2], we[2];
      logic [31:0] din[2], nsh[2];
      int nw;
      @(negedge clk);
      rst = rs; r0_req = q0; r0_we = w0; r0_din = d0; r1_req = q1; r1_we = w1; r1_din = d1;
      req[0] = q0; req[1] = q1; we[0] = w0; we[1] = w1; din[0] = d0; din[1] = d1;
      if (rs) begin
         m_owner = -1; m_held = 0; m_fav = 0; m_sh[0] = 0; m_sh[1] = 0; exp_last = 0;
      end else begin
         for (int i = 0; i < 2; i++) nsh[i] = we[i] ? din[i] : m_sh[i];
         if (m_owner < 0) nw = (req[0] && req[1]) ? m_fav : req[0] ? 0 : req[1] ? 1 : -1;
         else if (!req[m_owner]) nw = req[1-m_owner] ? 1 - m_owner : -1;
         else if (req[1-m_owner] && (m_held >= HOLD || (PRE && m_owner == 0))) nw = 1 - m_owner;
         else nw = m_owner;
         if (nw != m_owner) begin
            exp_last = nw < 0 ? IDLE_VAL : nsh[nw];
            exp_q.push_back(exp_last);
            if (nw >= 0) m_fav = 1 - nw;
            m_held = 1;
         end else if (m_owner >= 0) begin
            m_held++;
            if (we[m_owner]) begin
               exp_last = din[m_owner];
               exp_q.push_back(exp_last);
            end
         end
         m_owner = nw;
         for (int i = 0; i < 2; i++) m_sh[i] = nsh[i];
      end
      exp_gnt = m_owner == 0 ? 2'b01 : m_owner == 1 ? 2'b10 : 2'b00;
      armed = 1;
   endtask

   task automatic idle_n(input int n, input logic q0, input logic q1);
      for (int i = 0; i < n; i++) step(0, q0, 0, 0, q1, 0, 0);
   endtask

   initial begin
      logic [31:0] got;
      forever begin
         @(posedge clk);
         #1;
         if (armed) begin
            checks++;
            if ({r1_gnt, r0_gnt} !== exp_gnt) begin
               errors++;
               $display("FAIL gnt at %0t: got %b want %b", $time, {r1_gnt, r0_gnt}, exp_gnt);
            end
            checks++;
            if (seg_we === 1'b1) begin
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_write at %0t: seg_din %h, no write expected", $time, seg_din);
               end else begin
                  got = exp_q.pop_front();
                  if (seg_din !== got) begin
                     errors++;
                     $display("FAIL write_data at %0t: got %h want %h", $time, seg_din, got);
                  end
               end
            end else if (seg_we !== 1'b0) begin
               errors++;
               $display("FAIL seg_we at %0t: got %b want 0/1", $time, seg_we);
            end else if (seg_din !== exp_last) begin
               errors++;
               $display("FAIL hold_data at %0t: got %h want %h", $time, seg_din, exp_last);
            end
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL missing_write at %0t: seg_we %b want 1 with %h", $time, seg_we, exp_q[0]);
               exp_q.delete();
            end
         end
      end
   end

   initial begin
      logic q0, q1;
      // 1: first grant refreshes with the bypassed write data
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 32'h12345678, 0, 0, 0);
      idle_n(4, 1, 0);
      // 2 + 3: simultaneous requests alternate; r1 shadow written during r0 tenure
      step(1, 0, 0, 0, 0, 0, 0);
      idle_n(2, 1, 1);
      step(0, 1, 0, 0, 1, 1, 32'hDEADBEEF);
      idle_n(30, 1, 1);
      // 4: owner drops with nobody waiting, then a stray write while idle
      idle_n(3, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hCAFEF00D, 0, 0, 0);
      idle_n(2, 0, 0);
      // 5: reset while r1 owns and writes, then simultaneous request goes to r0
      idle_n(3, 0, 1);
      step(1, 0, 0, 0, 1, 1, 32'h0BADF00D);
      idle_n(3, 1, 1);
      // 6: r1 arrives 2 cycles into r0 tenure
      step(1, 0, 0, 0, 0, 0, 0);
      idle_n(2, 1, 0);
      idle_n(12, 1, 1);
      // randomized traffic with sticky requests so holds can expire
      q0 = 0; q1 = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) q0 = ~q0;
         if ($urandom_range(15) == 0) q1 = ~q1;
         step($urandom_range(199) == 0, q0, $urandom_range(3) == 0, $urandom,
              q1, $urandom_range(3) == 0, $urandom);
      end
      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
